// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the register bank.
// Shares a single write port (reg_we/reg_addr/reg_wdata) among NREQ requesters.
// The winner is selected at each rising edge, and the grant and write strobe are registered.
// A requester granted in one cycle is masked at the next edge, so it has time to drop req.
// Optional feature: define ARB_LOCK_EN to let a winner holding lock keep the port.
module regfile_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  reg_we,
  output logic [AW-1:0]         reg_addr,
  output logic [WIDTH-1:0]      reg_wdata,
  output logic                  busy,
  output logic [15:0]           grant_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [AW-1:0]    reg_addr_q, reg_addr_d;
  logic [WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [15:0]      grant_cnt_q, grant_cnt_d;

  logic [NREQ-1:0]  eligible;
  logic             found;
  logic [PW-1:0]    win;
  int               idx;
  logic             hold_lock;
  logic [PW-1:0]    owner;

  // The requester granted this cycle is excluded from the next selection.
  assign eligible = req & ~gnt_q;

  // Rotating-priority search: the first eligible index at or after ptr, wrapping around.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

`ifdef ARB_LOCK_EN
  // The lock owner is the requester currently holding the one-hot grant.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) owner = PW'(i);
    end
    hold_lock = (state_q == LOCKED) && req[owner] && lock[owner];
  end
`else
  logic lock_unused;
  assign lock_unused = ^lock;
  assign owner       = '0;
  assign hold_lock   = 1'b0;
`endif

  // Next-state logic: re-grant the lock owner, grant a new winner, or go idle.
  always_comb begin
    state_d     = IDLE;
    gnt_d       = '0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    ptr_d       = ptr_q;
    grant_cnt_d = grant_cnt_q;
    if (hold_lock) begin
      // The owner keeps the port, and the pointer stays frozen.
      state_d     = LOCKED;
      gnt_d       = gnt_q;
      reg_addr_d  = wr_addr[int'(owner)*AW +: AW];
      reg_wdata_d = wr_data[int'(owner)*WIDTH +: WIDTH];
      grant_cnt_d = grant_cnt_q + 16'd1;
    end else if (found) begin
      state_d     = GRANT;
`ifdef ARB_LOCK_EN
      if (lock[win]) state_d = LOCKED;
`endif
      gnt_d       = NREQ'(1) << win;
      reg_addr_d  = wr_addr[int'(win)*AW +: AW];
      reg_wdata_d = wr_data[int'(win)*WIDTH +: WIDTH];
      ptr_d       = (int'(win) == NREQ - 1) ? '0 : PW'(int'(win) + 1);
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  // State registers, cleared asynchronously by reset.
  // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      ptr_q       <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      ptr_q       <= ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign reg_we    = |gnt_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = (state_q != IDLE);
  assign grant_cnt = grant_cnt_q;

endmodule
